fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and decode. Fetch advances its PC every cycle and has no stall input, so this block absorbs fetched {nPC, IR} pairs while decode is stalled. It presents the oldest entry to decode with first-word-fall-through valid/ready semantics. It supports a branch flush and exposes occupancy and drop status for a future fetch-stall path.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1: width of the count output.
- DROPW, 16: width of the saturating drop counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch presents a new instruction this cycle.
- nPC_in  in  `WORD  PC+1 of the fetched instruction.
- IR_in  in  `WORD  fetched instruction word.
- in_ready  out  1  equals !full || pop; the entry is accepted when in_valid && in_ready.
- flush  in  1  discard all entries (branch taken / PCSrc).
- out_ready  in  1  decode accepts the head entry this cycle.
- out_valid  out  1  head entry is valid; equals !empty.
- nPC_out  out  `WORD  head nPC; 0 when empty.
- IR_out  out  `WORD  head IR; 0 when empty.
- count  out  CW  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- drop  out  1  one-cycle pulse when in_valid is asserted and the entry is not accepted.
- drop_cnt  out  DROPW  saturating count of dropped entries.

## Operation
- Storage: DEPTH entries of {nPC, IR}, 2×`WORD bits each. Read and write pointers are log2(DEPTH)+1 bits wide, with an extra wrap bit.
- full when the pointers differ only in the wrap bit. empty when the pointers are equal.
- pop = out_valid && out_ready. On pop, rd_ptr increments.
- push = in_valid && (!full || pop). On push, the entry is written at wr_ptr and wr_ptr increments.
- Push and pop in the same cycle: count is unchanged. This is legal when full; in_ready is 1 in that case.
- Empty queue: there is no bypass. out_valid stays 0 in the cycle of the first push.
- drop = in_valid && !push && !flush. drop_cnt increments on drop and saturates at all-ones.
- flush, checked after reset:
  - Pointers and count go to 0.
  - Any same-cycle push and pop are ignored.
  - drop is not asserted.
  - drop_cnt is kept.
- reset, highest priority:
  - Pointers, count and drop_cnt go to 0.
  - Storage contents are don't-care, since the outputs are gated by empty.
- nPC_out and IR_out are the head entry when !empty, otherwise 0.
- Pointer arithmetic wraps modulo 2·DEPTH. The index is the low log2(DEPTH) bits.

## Timing
- Reset values: out_valid 0, nPC_out 0, IR_out 0, count 0, full 0, empty 1, in_ready 1, drop 0, drop_cnt 0.
- Push-to-visible latency is 1 cycle: an entry pushed at edge N is on the outputs after edge N. out_valid, count, full, empty and in_ready all reflect the new state from that edge.
- Outputs change only on clk edges, except these combinational paths:
  - in_ready depends on out_ready.
  - drop depends on in_valid, out_ready and flush.
- Reset or flush asserted mid-stream: the queue is empty from the next edge, and later entries must be pushed again.
- Maximum throughput is one push and one pop per cycle, sustained at any occupancy.

## Structure
- `WORD comes from definitions.vh.
- Add `FQ_ENTRY = 2*`WORD to definitions.vh so decode can share it.
- One sub-module, fq_storage: a DEPTH×`FQ_ENTRY register array with one synchronous write port and one asynchronous read port.
- Pointer logic, flags and the drop counter live in fetch_queue.

## Test plan
- Reset, then idle: out_valid=0, empty=1, count=0, in_ready=1, outputs 0.
- Push nPC=1/IR=0x20080005 and nPC=2/IR=0x20090003 with out_ready=0: count=2, head shows nPC=1. Raise out_ready for 1 cycle: head becomes nPC=2, count=1.
- Fill with DEPTH=4 entries, out_ready=0:
  - full=1, in_ready=0.
  - A fifth in_valid gives a drop pulse and drop_cnt=1.
  - Then assert in_valid and out_ready together: push and pop both occur, count stays 4, head advances, no drop.
- Three entries queued, flush asserted with in_valid=1 and out_ready=1: next cycle empty=1, count=0, drop=0, drop_cnt unchanged.
- Continuous streaming of nPC 1..100 with out_ready toggling randomly: output order matches input order, with no loss while full is never reached.
- Force drop_cnt to 0xFFFF, then drop again: drop_cnt stays 0xFFFF. Reset clears it to 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared word widths and the queue entry layout.
// `WORD is the machine word width. `FQ_ENTRY is one {nPC, IR} entry, which
// decode can reuse to unpack the queue head.
`ifndef WORD
`define WORD 32
`endif
`ifndef FQ_ENTRY
`define FQ_ENTRY (2*`WORD)
`endif

package fetch_queue_pkg;

  localparam int WORD_W  = `WORD;
  localparam int ENTRY_W = `FQ_ENTRY;

  // The layout of one entry: nPC in the upper word and IR in the lower word.
  typedef struct packed {
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] ir;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH x `FQ_ENTRY register array.
// Ports:
//   clk    - rising-edge clock
//   we     - write enable; wdata is stored at waddr on the edge
//   waddr  - write index
//   wdata  - entry to store
//   raddr  - read index
//   rdata  - entry at raddr (asynchronous read)
// The array has no reset. The owner gates the outputs with its empty flag.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between fetch and decode.
// Fetch cannot stall. This queue absorbs the {nPC, IR} pairs it produces while
// decode is stalled, and shows the oldest entry to decode (first-word
// fall-through).
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   in_valid, nPC_in, IR_in, in_ready    - fetch side
//   flush             - discard all entries (taken branch)
//   out_valid, nPC_out, IR_out, out_ready - decode side
//   count, full, empty                    - occupancy
//   drop, drop_cnt    - entry-lost pulse and saturating count of lost entries
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int DROPW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [`WORD-1:0]  nPC_in,
  input  logic [`WORD-1:0]  IR_in,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [`WORD-1:0]  nPC_out,
  output logic [`WORD-1:0]  IR_out,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              drop,
  output logic [DROPW-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Increment, but hold at all-ones instead of wrapping.
  function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
    return (&v) ? v : v + DROPW'(1);
  endfunction

  // The extra MSB on each pointer is the wrap bit. It tells full apart from empty.
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    occ;
  logic [DROPW-1:0] drop_cnt_q;
  logic             push, pop;
  fq_entry_t        wdata, rdata;

  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign count = CW'(occ);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full queue can still accept an entry when the head leaves in the same cycle.
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;
  assign drop      = in_valid && !push && !flush;
  assign drop_cnt  = drop_cnt_q;

  assign wdata.npc = nPC_in;
  assign wdata.ir  = IR_in;

  fq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // Storage is not reset, so the head is gated to zero while the queue is empty.
  assign nPC_out = empty ? '0 : rdata.npc;
  assign IR_out  = empty ? '0 : rdata.ir;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_cnt_q <= '0;
    end else if (flush) begin
      // Same-cycle push and pop are discarded. The drop history is kept.
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int DROPW = 16;

  logic              clk = 1'b0;
  logic              reset, in_valid, flush, out_ready;
  logic [WORD_W-1:0] nPC_in, IR_in, nPC_out, IR_out;
  logic              in_ready, out_valid, full, empty, drop;
  logic [CW-1:0]     count;
  logic [DROPW-1:0]  drop_cnt;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW), .DROPW(DROPW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .nPC_in(nPC_in), .IR_in(IR_in),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .nPC_out(nPC_out), .IR_out(IR_out), .count(count), .full(full), .empty(empty),
    .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  fq_entry_t        sb[$];
  logic [DROPW-1:0] m_drop_cnt;
  bit               do_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [WORD_W-1:0] npc,
                       input logic [WORD_W-1:0] ir, input logic ordy, input logic fl);
    in_valid = v; nPC_in = npc; IR_in = ir; out_ready = ordy; flush = fl;
  endtask

  // Check outputs mid-cycle against the scoreboard, then step the model over the edge.
  task automatic step();
    int        sz;
    bit        m_pop, m_push, m_drop;
    fq_entry_t e;
    #3;
    sz     = sb.size();
    m_pop  = (sz > 0) && out_ready;
    m_push = in_valid && ((sz < DEPTH) || m_pop);
    m_drop = in_valid && !m_push && !flush;
    if (do_chk) begin
      chk("out_valid", 64'(out_valid), 64'(sz > 0));
      chk("nPC_out",   64'(nPC_out),   (sz > 0) ? 64'(sb[0].npc) : 64'd0);
      chk("IR_out",    64'(IR_out),    (sz > 0) ? 64'(sb[0].ir)  : 64'd0);
      chk("count",     64'(count),     64'(sz));
      chk("full",      64'(full),      64'(sz == DEPTH));
      chk("empty",     64'(empty),     64'(sz == 0));
      chk("in_ready",  64'(in_ready),  64'((sz < DEPTH) || m_pop));
      chk("drop",      64'(drop),      64'(m_drop));
      chk("drop_cnt",  64'(drop_cnt),  64'(m_drop_cnt));
    end
    if (reset) begin
      sb.delete();
      m_drop_cnt = '0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        e.npc = nPC_in; e.ir = IR_in;
        sb.push_back(e);
      end
      if (m_drop && m_drop_cnt != '1) m_drop_cnt = m_drop_cnt + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    int guard;
    m_drop_cnt = '0;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_chk = 1'b0;
    step();
    reset  = 1'b0;
    do_chk = 1'b1;

    // Idle after reset
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_empty",    64'(empty),    64'd1);

    // Two pushes, then one pop
    drive(1'b1, 32'd1, 32'h2008_0005, 1'b0, 1'b0); step();
    drive(1'b1, 32'd2, 32'h2009_0003, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_head",  64'(nPC_out), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();
    chk("t2_head2", 64'(nPC_out), 64'd2);
    chk("t2_count2", 64'(count), 64'd1);

    // Fill to full, drop one, then push and pop together at full
    for (int i = 3; i <= 5; i++) begin
      drive(1'b1, 32'(i), 32'h1000_0000 | 32'(i), 1'b0, 1'b0); step();
    end
    chk("t3_full", 64'(full), 64'd1);
    drive(1'b1, 32'd6, 32'h1000_0006, 1'b0, 1'b0); step();
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    drive(1'b1, 32'd7, 32'h1000_0007, 1'b1, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();
    chk("t3_count4", 64'(count), 64'd4);
    chk("t3_head",   64'(nPC_out), 64'd3);

    // Drain to three entries, then flush with push and pop requested
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    drive(1'b1, 32'd8, 32'h1000_0008, 1'b1, 1'b1); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);

    // Streaming 1..100 with random valid/ready
    idx = 1; guard = 0;
    while (idx <= 100 && guard < 3000) begin
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, 32'(idx), 32'h3000_0000 | 32'(idx), 1'($urandom_range(0, 1)), 1'b0);
      else
        drive(1'b0, '0, '0, 1'($urandom_range(0, 1)), 1'b0);
      if (in_valid && in_ready) idx++;
      step();
      guard++;
    end
    chk("stream_done", 64'(idx), 64'd101);
    guard = 0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    while (sb.size() > 0 && guard < 20) begin step(); guard++; end
    chk("stream_drained", 64'(empty), 64'd1);

    // Saturate the drop counter
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(200 + i), 32'h4000_0000, 1'b0, 1'b0); step();
    end
    do_chk = 1'b0;
    drive(1'b1, 32'd300, 32'h4000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step();
    do_chk = 1'b1;
    step();
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
    step();
    chk("sat_hold2", 64'(drop_cnt), 64'hFFFF);

    // Reset clears the counter
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    step();
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_count",    64'(count),    64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
